// File: rtl/fas_pkg.sv
// Shared constants and scheduler state encoding for the FIR-to-FFT frame scheduler.
package fas_pkg;
    localparam int FRAME_LEN  = 16;
    localparam int NUM_FRAMES = 64;
    localparam int SAMPLE_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_FFT,
        ST_OUT,
        ST_ANA,
        ST_FIN
    } sched_state_t;
endpackage

// File: rtl/fas_frame_buf.sv
// Two-bank ping-pong frame storage: one write port, one registered read port.
// Only the read register is reset; sample storage keeps its contents across rst.
module fas_frame_buf #(
    parameter int DEPTH = fas_pkg::FRAME_LEN,
    parameter int W     = fas_pkg::SAMPLE_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_bank][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_bank][rd_addr];
    end
endmodule

// File: rtl/fas_sched.sv
// Ping-pong frame scheduler between a FIR sample stream, an FFT core and an analyser.
// Define FAS_SCHED_OVERRUN_EN to build the sticky overrun detector; otherwise overrun is tied 0.
module fas_sched #(
    parameter int FRAME_LEN  = fas_pkg::FRAME_LEN,
    parameter int NUM_FRAMES = fas_pkg::NUM_FRAMES,
    localparam int AW        = $clog2(FRAME_LEN),
    localparam int CW        = $clog2(NUM_FRAMES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fir_valid,
    input  logic [fas_pkg::SAMPLE_W-1:0] fir_d,
    input  logic [AW-1:0]                rd_addr,
    output logic [fas_pkg::SAMPLE_W-1:0] rd_data,
    output logic                         fft_start,
    output logic                         fft_bank,
    input  logic                         fft_done,
    output logic                         fft_valid,
    output logic                         ana_start,
    input  logic                         ana_done,
    output logic                         done,
    output logic [CW-1:0]                frame_cnt,
    output logic                         overrun
);
    import fas_pkg::*;

    sched_state_t  state;
    logic [1:0]    full;
    logic [1:0]    full_nxt;
    logic          wb;
    logic [AW-1:0] wr_ptr;
    logic          bank_free;
    logic          wr_acc;
    logic          wr_wrap;

    // wb only points at a full bank when both are full, so !full[wb] is the accept test.
    assign bank_free = (state == ST_WAIT_FFT) && fft_done;
    assign wr_acc    = fir_valid && (state != ST_FIN) && !full[wb];
    assign wr_wrap   = wr_acc && (wr_ptr == AW'(FRAME_LEN - 1));

    always_comb begin
        full_nxt = full;
        if (bank_free)
            full_nxt[fft_bank] = 1'b0;
        if (wr_wrap)
            full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= '0;
            wb     <= 1'b0;
            wr_ptr <= '0;
        end else begin
            full <= full_nxt;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            // Move off a full bank as soon as the other one is free, including a same-cycle release.
            if (full_nxt[wb] && !full_nxt[~wb])
                wb <= ~wb;
        end
    end

`ifdef FAS_SCHED_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else if (fir_valid && (state != ST_FIN) && (&full))
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fft_start <= 1'b0;
            fft_bank  <= 1'b0;
            fft_valid <= 1'b0;
            ana_start <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|full) begin
                        state     <= ST_START;
                        fft_start <= 1'b1;
                        // With a full bank present the oldest one is always the non-write bank.
                        fft_bank  <= full[~wb] ? ~wb : wb;
                    end
                end
                ST_START: begin
                    fft_start <= 1'b0;
                    state     <= ST_WAIT_FFT;
                end
                ST_WAIT_FFT: begin
                    if (fft_done) begin
                        fft_valid <= 1'b1;
                        ana_start <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    fft_valid <= 1'b0;
                    ana_start <= 1'b0;
                    state     <= ST_ANA;
                end
                ST_ANA: begin
                    if (ana_done) begin
                        if (frame_cnt == CW'(NUM_FRAMES - 1)) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_FIN: begin
                    done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fas_frame_buf #(
        .DEPTH (FRAME_LEN),
        .W     (SAMPLE_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_bank (wb),
        .wr_addr (wr_ptr),
        .wr_data (fir_d),
        .rd_bank (fft_bank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule
